// File: rtl/modmul_arbiter.sv
// Round-robin arbiter sharing one multi-cycle multiplier among NREQ requesters.
// A watchdog turns a multiplier that never completes into an error response.
module modmul_arbiter #(
    parameter int unsigned N    = 64,
    parameter int unsigned NREQ = 4,
    parameter int unsigned WDOG = 8 * N + 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*N-1:0]       req_a,
    input  logic [NREQ*N-1:0]       req_b,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [$clog2(NREQ)-1:0] resp_id,
    output logic [N-1:0]            resp_result,
    output logic                    resp_err,
    output logic                    mul_reset,
    output logic [N-1:0]            mul_a,
    output logic [N-1:0]            mul_b,
    input  logic                    mul_done,
    input  logic [N-1:0]            mul_result,
    output logic                    busy
);

    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned CW  = $clog2(WDOG + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_LAUNCH,
        S_WAIT,
        S_RESP
    } state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [N-1:0]    mul_a_q, mul_a_d;
    logic [N-1:0]    mul_b_q, mul_b_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   cnt_inc;
    logic [N-1:0]    res_q, res_d;
    logic            err_q, err_d;
    logic            resp_valid_q, resp_valid_d;
    logic            mul_reset_q, mul_reset_d;
    logic            busy_q, busy_d;
    logic [NREQ-1:0] req_ready_c;
    logic            pick_found_c;
    logic [IDW-1:0]  pick_idx_c;

    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int unsigned off);
        return IDW'((32'(base) + off) % NREQ);
    endfunction

    // Scan from the highest offset down so the requester closest to ptr wins.
    always_comb begin : rr_pick
        pick_found_c = 1'b0;
        pick_idx_c   = '0;
        for (int unsigned k = NREQ; k > 0; k--) begin
            if (req_valid[rr_index(ptr_q, k - 1)]) begin
                pick_found_c = 1'b1;
                pick_idx_c   = rr_index(ptr_q, k - 1);
            end
        end
    end

    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin : fsm_next
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        cnt_d       = cnt_q;
        res_d       = res_q;
        err_d       = err_q;
        req_ready_c = '0;

        case (state_q)
            S_IDLE: begin
                if (|req_valid) state_d = S_GRANT;
            end
            S_GRANT: begin
                if (pick_found_c) begin
                    req_ready_c = NREQ'(1) << pick_idx_c;
                    id_d        = pick_idx_c;
                    ptr_d       = rr_index(pick_idx_c, 1);
                    mul_a_d     = req_a[32'(pick_idx_c) * N +: N];
                    mul_b_d     = req_b[32'(pick_idx_c) * N +: N];
                    state_d     = S_LAUNCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                if (mul_done) begin
                    res_d   = mul_result;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_inc == CW'(WDOG)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Per-state outputs are registered from the next state so they align with it.
        mul_reset_d  = !(state_d == S_LAUNCH || state_d == S_WAIT);
        busy_d       = (state_d != S_IDLE);
        resp_valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge clock) begin : regs
        if (reset) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            id_q         <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            cnt_q        <= '0;
            res_q        <= '0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            mul_reset_q  <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            cnt_q        <= cnt_d;
            res_q        <= res_d;
            err_q        <= err_d;
            resp_valid_q <= resp_valid_d;
            mul_reset_q  <= mul_reset_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready   = req_ready_c;
    assign resp_valid  = resp_valid_q;
    assign resp_id     = id_q;
    assign resp_result = res_q;
    assign resp_err    = err_q;
    assign mul_reset   = mul_reset_q;
    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_modmul_arbiter.sv
// Directed bench for modmul_arbiter (N=8, NREQ=4, WDOG=128) with a behavioural
// multiplier whose latency is set per vector.
module tb_modmul_arbiter;

    logic        clock;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_id;
    logic [7:0]  resp_result;
    logic        resp_err;
    logic        mul_reset;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic        mul_done;
    logic [7:0]  mul_result;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    modmul_arbiter #(.N(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_result(resp_result),
        .resp_err   (resp_err),
        .mul_reset  (mul_reset),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_done   (mul_done),
        .mul_result (mul_result),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Multiplier model: done rises in the mul_lat-th cycle after the launch cycle; 0 = never.
    int         mul_lat = 1;
    int         m_cnt;
    logic       m_done;
    logic [7:0] m_res;
    logic       force_done = 1'b0;

    always @(posedge clock) begin
        if (mul_reset) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_res  <= '0;
        end else begin
            m_cnt  <= m_cnt + 1;
            m_done <= 1'b0;
            if (mul_lat != 0 && m_cnt == mul_lat - 1) begin
                m_done <= 1'b1;
                m_res  <= 8'(mul_a * mul_b);
            end
        end
    end

    assign mul_done   = m_done | force_done;
    assign mul_result = m_res;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        int          hold;
        logic [3:0]  exp_ready;
        logic [1:0]  exp_id;
        logic [7:0]  exp_res;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] valid, input logic [31:0] a, input logic [31:0] b,
                                input int lat, input int hold, input logic [3:0] exp_ready,
                                input logic [1:0] exp_id, input logic [7:0] exp_res,
                                input logic exp_err, input int exp_lat);
        vec_t v;
        v.valid = valid; v.a = a; v.b = b; v.lat = lat; v.hold = hold;
        v.exp_ready = exp_ready; v.exp_id = exp_id; v.exp_res = exp_res;
        v.exp_err = exp_err; v.exp_lat = exp_lat;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_req_ready"},   64'(req_ready),   64'(0));
        check({tag, "_resp_valid"},  64'(resp_valid),  64'(0));
        check({tag, "_resp_err"},    64'(resp_err),    64'(0));
        check({tag, "_resp_id"},     64'(resp_id),     64'(0));
        check({tag, "_resp_result"}, 64'(resp_result), 64'(0));
        check({tag, "_mul_reset"},   64'(mul_reset),   64'(1));
        check({tag, "_mul_ab"},      64'({mul_a, mul_b}), 64'(0));
        check({tag, "_busy"},        64'(busy),        64'(0));
    endtask

    // One full transaction from IDLE: grant, launch, wait, optional held response, accept.
    task automatic run_txn(input string tag, input vec_t v);
        int         cycles;
        int         low_cnt;
        int         unstable;
        int         bad_rdy;
        logic [7:0] a0, b0;
        req_a     = v.a;
        req_b     = v.b;
        mul_lat   = v.lat;
        req_valid = v.valid;
        tick;
        check({tag, "_grant"}, 64'(req_ready), 64'(v.exp_ready));
        check({tag, "_busy"},  64'(busy),      64'(1));
        cycles = 0; low_cnt = 0; unstable = 0; bad_rdy = 0;
        a0 = '0; b0 = '0;
        while (!resp_valid && cycles < 300) begin
            tick;
            cycles++;
            if (cycles == 1) begin
                req_valid = '0;
                a0 = mul_a;
                b0 = mul_b;
                check({tag, "_mul_a"}, 64'(mul_a), 64'(v.a[int'(v.exp_id) * 8 +: 8]));
                check({tag, "_mul_b"}, 64'(mul_b), 64'(v.b[int'(v.exp_id) * 8 +: 8]));
            end
            if (!mul_reset) begin
                low_cnt++;
                if (mul_a !== a0 || mul_b !== b0) unstable++;
            end
            if (req_ready !== 4'b0000) bad_rdy++;
        end
        check({tag, "_latency"},     64'(cycles),      64'(v.exp_lat));
        check({tag, "_mulrst_low"},  64'(low_cnt),     64'(v.exp_lat - 1));
        check({tag, "_operand_hold"}, 64'(unstable),   64'(0));
        check({tag, "_no_ready"},    64'(bad_rdy),     64'(0));
        check({tag, "_resp_id"},     64'(resp_id),     64'(v.exp_id));
        check({tag, "_resp_result"}, 64'(resp_result), 64'(v.exp_res));
        check({tag, "_resp_err"},    64'(resp_err),    64'(v.exp_err));
        for (int h = 0; h < v.hold; h++) begin
            req_valid  = 4'b1111;
            force_done = (h == 3);
            #1;
            check({tag, "_hold_valid"}, 64'(resp_valid), 64'(1));
            check({tag, "_hold_data"},  64'({resp_id, resp_result, resp_err}),
                  64'({v.exp_id, v.exp_res, v.exp_err}));
            check({tag, "_hold_ready"}, 64'(req_ready), 64'(0));
            check({tag, "_hold_mulrst"}, 64'(mul_reset), 64'(1));
            tick;
        end
        force_done = 1'b0;
        req_valid  = '0;
        resp_ready = 1'b1;
        tick;
        resp_ready = 1'b0;
        check({tag, "_drop_valid"}, 64'({resp_valid, busy}), 64'(0));
        check({tag, "_idle_mulrst"}, 64'(mul_reset), 64'(1));
    endtask

    vec_t vecs[6];
    vec_t post[2];
    int   exp_seq[5] = '{0, 1, 2, 3, 0};
    int   exp_prd[5] = '{5, 12, 21, 32, 5};

    initial begin
        int g, r, bad;
        vecs[0] = mk(4'b0100, {8'd9, 8'd7, 8'd3, 8'd2},     {8'd4, 8'd5, 8'd6, 8'd8},   3, 10, 4'b0100, 2'd2, 8'd35,  1'b0, 5);
        vecs[1] = mk(4'b0001, {8'd1, 8'd2, 8'd3, 8'd255},   {8'd1, 8'd1, 8'd1, 8'd255}, 1, 0,  4'b0001, 2'd0, 8'd1,   1'b0, 3);
        vecs[2] = mk(4'b1001, {8'd200, 8'd2, 8'd3, 8'd4},   {8'd3, 8'd5, 8'd5, 8'd5},   4, 2,  4'b1000, 2'd3, 8'd88,  1'b0, 6);
        vecs[3] = mk(4'b0110, {8'd1, 8'd1, 8'd13, 8'd9},    {8'd1, 8'd1, 8'd11, 8'd9},  2, 0,  4'b0010, 2'd1, 8'd143, 1'b0, 4);
        vecs[4] = mk(4'b0011, {8'd5, 8'd5, 8'd5, 8'd16},    {8'd5, 8'd5, 8'd5, 8'd16},  2, 0,  4'b0001, 2'd0, 8'd0,   1'b0, 4);
        vecs[5] = mk(4'b0010, {8'd4, 8'd4, 8'd6, 8'd4},     {8'd4, 8'd4, 8'd7, 8'd4},   0, 0,  4'b0010, 2'd1, 8'd0,   1'b1, 130);
        post[0] = mk(4'b1001, {8'd10, 8'd0, 8'd0, 8'd6},    {8'd10, 8'd0, 8'd0, 8'd7},  2, 0,  4'b0001, 2'd0, 8'd42,  1'b0, 4);
        post[1] = mk(4'b1000, {8'd12, 8'd0, 8'd0, 8'd0},    {8'd12, 8'd0, 8'd0, 8'd0},  3, 0,  4'b1000, 2'd3, 8'd144, 1'b0, 5);

        reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
        tick;
        tick;
        check_reset_state("por");
        reset = 1'b0;

        for (int i = 0; i < 6; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

        // Spurious done while idle must not wake the arbiter.
        force_done = 1'b1;
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            tick;
            if (busy || resp_valid) bad++;
        end
        force_done = 1'b0;
        check("idle_done_ignored", 64'(bad), 64'(0));

        // Abort mid-WAIT with reset.
        mul_lat   = 40;
        req_a     = {8'd1, 8'd9, 8'd1, 8'd1};
        req_b     = {8'd1, 8'd9, 8'd1, 8'd1};
        req_valid = 4'b0100;
        tick;
        check("abort_grant", 64'(req_ready), 64'(4'b0100));
        tick;
        req_valid = '0;
        tick;
        tick;
        tick;
        check("abort_in_wait", 64'({busy, mul_reset}), 64'(2'b10));
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check_reset_state("abort");
        bad = 0;
        for (int c = 0; c < 60; c++) begin
            tick;
            if (resp_valid || busy) bad++;
        end
        check("abort_no_resp", 64'(bad), 64'(0));
        run_txn("post0", post[0]);
        run_txn("post1", post[1]);

        // All four requesting continuously from ptr=0.
        reset = 1'b1;
        tick;
        reset = 1'b0;
        req_a      = {8'd1, 8'd1, 8'd1, 8'd1};
        req_b      = {8'd32, 8'd21, 8'd12, 8'd5};
        mul_lat    = 2;
        resp_ready = 1'b1;
        req_valid  = 4'b1111;
        g = 0;
        r = 0;
        for (int c = 0; c < 200 && r < 5; c++) begin
            tick;
            if (req_ready !== 4'b0000) begin
                check("rr_onehot", 64'($onehot(req_ready)), 64'(1));
                if (g < 5) check($sformatf("rr_grant%0d", g), 64'(req_ready), 64'(4'b0001 << exp_seq[g]));
                g++;
            end
            if (resp_valid) begin
                if (r < 5) begin
                    check($sformatf("rr_id%0d", r),  64'(resp_id),     64'(exp_seq[r]));
                    check($sformatf("rr_res%0d", r), 64'(resp_result), 64'(exp_prd[r]));
                end
                r++;
            end
        end
        check("rr_grants", 64'(g), 64'(5));
        check("rr_resps",  64'(r), 64'(5));
        req_valid = '0;
        tick;
        resp_ready = 1'b0;
        tick;
        check("rr_final_idle", 64'({busy, resp_valid}), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, %0d checks done", n_checks);
        $fatal(1);
    end

endmodule
